counter_bank: RTL

COUNTER_BANK -- requirements
Module: counter_bank

---
 rtl/counter_bank_pkg.sv | 12 +
 rtl/counter_bank_if.sv | 13 +
 rtl/counter_chan.sv | 87 ++++++++
 rtl/counter_bank.sv | 52 +++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Shared constants and helpers for the counter bank.
package counter_bank_pkg;

    localparam logic CNT_UP = 1'b0;
    localparam logic CNT_DN = 1'b1;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Shared load/compare write bus, fanned out to every counter channel.
interface counter_bank_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 2
);
    logic             load_en;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] load_val;
    logic             cmp_wr;

    modport master (output load_en, sel, load_val, cmp_wr);
    modport slave  (input  load_en, sel, load_val, cmp_wr);
endinterface

// File: rtl/counter_chan.sv
// One up/down counter channel with wrap pulse and, when COUNTER_BANK_CMP_EN
// is defined, a compare register with a sticky match flag.
module counter_chan
    import counter_bank_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      SEL_W  = 2,
    parameter int unsigned      IDX    = 0,
    parameter logic [WIDTH-1:0] PRESET = '0
) (
    input  logic             clk,
    input  logic             resetn,
    counter_bank_if.slave    bus,
    input  logic             inc_i,
    input  logic             dn_i,
    input  logic             match_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o,
    output logic             match_o
);

    logic             sel_hit_c;
    logic             load_hit_c;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    assign sel_hit_c  = (bus.sel == SEL_W'(IDX));
    assign load_hit_c = bus.load_en && sel_hit_c;

    // A load wins over a count and never produces a wrap pulse.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load_hit_c) begin
            cnt_d = bus.load_val;
        end else if (inc_i) begin
            if (dn_i == CNT_DN) begin
                cnt_d  = cnt_q - WIDTH'(1);
                wrap_d = (cnt_q == '0);
            end else begin
                cnt_d  = cnt_q + WIDTH'(1);
                wrap_d = (cnt_q == '1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= PRESET;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = cnt_q;
    assign wrap_o = wrap_q;

`ifdef COUNTER_BANK_CMP_EN
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             match_q, match_d;

    // Next counter value is compared against the compare value in force this cycle.
    always_comb begin
        cmp_d   = (bus.cmp_wr && sel_hit_c) ? bus.load_val : cmp_q;
        match_d = (cnt_d == cmp_q) || (match_q && !match_clr_i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_q   <= '1;
            match_q <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;
`else
    logic unused_cmp_c;
    assign unused_cmp_c = bus.cmp_wr ^ match_clr_i;
    assign match_o      = 1'b0;
`endif

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent up/down counters sharing one load bus.
// Compare/match logic is built only when COUNTER_BANK_CMP_EN is defined.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      CHANNELS = 4,
    parameter logic [WIDTH-1:0] PRESET   = '0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [CHANNELS-1:0]           inc,
    input  logic [CHANNELS-1:0]           dn,
    input  logic                          load_en,
    input  logic [sel_width(CHANNELS)-1:0] sel,
    input  logic [WIDTH-1:0]              load_val,
    input  logic                          cmp_wr,
    input  logic [CHANNELS-1:0]           match_clr,
    output logic [CHANNELS*WIDTH-1:0]     q,
    output logic [CHANNELS-1:0]           wrap,
    output logic [CHANNELS-1:0]           match
);

    localparam int unsigned SEL_W = sel_width(CHANNELS);

    counter_bank_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    assign bus.load_en  = load_en;
    assign bus.sel      = sel;
    assign bus.load_val = load_val;
    assign bus.cmp_wr   = cmp_wr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        counter_chan #(
            .WIDTH  (WIDTH),
            .SEL_W  (SEL_W),
            .IDX    (i),
            .PRESET (PRESET)
        ) u_chan (
            .clk         (clk),
            .resetn      (resetn),
            .bus         (bus),
            .inc_i       (inc[i]),
            .dn_i        (dn[i]),
            .match_clr_i (match_clr[i]),
            .q_o         (q[i*WIDTH +: WIDTH]),
            .wrap_o      (wrap[i]),
            .match_o     (match[i])
        );
    end

endmodule
